fxp32_add_arb: RTL and testbench

FXP32_ADD_ARB -- requirements
Module: fxp32_add_arb

---
 rtl/fxp32_pkg.sv | 19 +
 rtl/fxp32_cla.sv | 62 ++++++
 rtl/fxp32_add_arb.sv | 129 ++++++++++++
 tb/tb_fxp32_add_arb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp32_pkg.sv
// Shared widths, response-slot state encoding and small helpers for the
// fxp32 shared-adder arbiter.
package fxp32_pkg;

  localparam int FXP32_WIDTH = 32;
  localparam int OPCNT_WIDTH = 16;
  localparam int CLA_GROUP   = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  // Two's-complement overflow: carry into the sign bit disagrees with carry out of it.
  function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/fxp32_cla.sv
// 32-bit carry-lookahead adder built from 4-bit lookahead groups; also exposes
// the carry into the sign bit so the caller can detect signed overflow.
module fxp32_cla
  import fxp32_pkg::*;
(
  input  logic [FXP32_WIDTH-1:0] a_i,
  input  logic [FXP32_WIDTH-1:0] b_i,
  input  logic                   cin_i,
  output logic [FXP32_WIDTH-1:0] sum_o,
  output logic                   c_msb_o,
  output logic                   cout_o
);

  localparam int NGRP = FXP32_WIDTH / CLA_GROUP;

  logic [FXP32_WIDTH-1:0] gen_bit;
  logic [FXP32_WIDTH-1:0] prop_bit;
  logic [FXP32_WIDTH-1:0] carry_bit;
  logic [NGRP-1:0]        grp_gen;
  logic [NGRP-1:0]        grp_prop;
  logic [NGRP:0]          grp_carry;

  assign gen_bit  = a_i & b_i;
  assign prop_bit = a_i ^ b_i;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      localparam int B = CLA_GROUP * gi;

      assign grp_gen[gi] = gen_bit[B+3]
                         | (prop_bit[B+3] & gen_bit[B+2])
                         | (prop_bit[B+3] & prop_bit[B+2] & gen_bit[B+1])
                         | (prop_bit[B+3] & prop_bit[B+2] & prop_bit[B+1] & gen_bit[B]);
      assign grp_prop[gi] = &prop_bit[B+3:B];

      assign carry_bit[B]   = grp_carry[gi];
      assign carry_bit[B+1] = gen_bit[B] | (prop_bit[B] & grp_carry[gi]);
      assign carry_bit[B+2] = gen_bit[B+1]
                            | (prop_bit[B+1] & gen_bit[B])
                            | (prop_bit[B+1] & prop_bit[B] & grp_carry[gi]);
      assign carry_bit[B+3] = gen_bit[B+2]
                            | (prop_bit[B+2] & gen_bit[B+1])
                            | (prop_bit[B+2] & prop_bit[B+1] & gen_bit[B])
                            | (prop_bit[B+2] & prop_bit[B+1] & prop_bit[B] & grp_carry[gi]);
    end
  endgenerate

  // Group carries only depend on group generate/propagate terms, never on bit carries.
  always_comb begin
    grp_carry    = '0;
    grp_carry[0] = cin_i;
    for (int i = 0; i < NGRP; i++) begin
      grp_carry[i+1] = grp_gen[i] | (grp_prop[i] & grp_carry[i]);
    end
  end

  assign sum_o   = prop_bit ^ carry_bit;
  assign c_msb_o = carry_bit[FXP32_WIDTH-1];
  assign cout_o  = grp_carry[NGRP];

endmodule

// File: rtl/fxp32_add_arb.sv
// Round-robin arbiter sharing one CLA adder among NREQ requesters, with a
// single registered response slot and a wrapping response counter.
module fxp32_add_arb
  import fxp32_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*FXP32_WIDTH-1:0] req_a,
  input  logic [NREQ*FXP32_WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]             req_sub,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [FXP32_WIDTH-1:0]      rsp_sum,
  output logic                        rsp_ovf,
  output logic [IDW-1:0]              rsp_id,
  output logic [OPCNT_WIDTH-1:0]      op_count
);

  rsp_state_e             state_q;
  logic [IDW-1:0]         ptr_q;
  logic [FXP32_WIDTH-1:0] sum_q;
  logic                   ovf_q;
  logic [IDW-1:0]         id_q;
  logic [OPCNT_WIDTH-1:0] cnt_q;
  logic [OPCNT_WIDTH-1:0] cnt_d;

  logic [FXP32_WIDTH-1:0] a_arr [NREQ];
  logic [FXP32_WIDTH-1:0] b_arr [NREQ];

  logic                   grant_found;
  logic [IDW-1:0]         grant_idx;
  logic [IDW-1:0]         cand_idx;
  logic                   slot_free;
  logic                   xfer;
  logic                   rsp_fire;

  logic [FXP32_WIDTH-1:0] op_a;
  logic [FXP32_WIDTH-1:0] op_b;
  logic                   op_cin;
  logic [FXP32_WIDTH-1:0] sum_d;
  logic                   c_msb;
  logic                   c_out;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]     = req_a[FXP32_WIDTH*gi +: FXP32_WIDTH];
      assign b_arr[gi]     = req_b[FXP32_WIDTH*gi +: FXP32_WIDTH];
      assign req_ready[gi] = xfer && (grant_idx == IDW'(gi));
    end
  endgenerate

  // First valid requester after the last winner, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = rr_idx(ptr_q, k);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign slot_free = !rsp_valid || rsp_ready;
  assign xfer      = grant_found && slot_free && !rst;

  // Subtract is A + ~B + 1 through the same adder.
  assign op_a   = a_arr[grant_idx];
  assign op_b   = req_sub[grant_idx] ? ~b_arr[grant_idx] : b_arr[grant_idx];
  assign op_cin = req_sub[grant_idx];

  fxp32_cla u_cla (
    .a_i     (op_a),
    .b_i     (op_b),
    .cin_i   (op_cin),
    .sum_o   (sum_d),
    .c_msb_o (c_msb),
    .cout_o  (c_out)
  );

  assign cnt_d = rsp_fire ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= IDW'(NREQ - 1);
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (xfer) begin
        ptr_q <= grant_idx;
        sum_q <= sum_d;
        ovf_q <= signed_ovf(c_msb, c_out);
        id_q  <= grant_idx;
      end
      case (state_q)
        ST_EMPTY: if (xfer) state_q <= ST_FULL;
        ST_FULL:  if (rsp_ready && !xfer) state_q <= ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

  assign rsp_sum  = sum_q;
  assign rsp_ovf  = ovf_q;
  assign rsp_id   = id_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_fxp32_add_arb.sv
// Directed bench for fxp32_add_arb: a cycle model of the arbiter/adder checked on
// every falling edge, plus hand-computed literal expectations per scenario.
module tb_fxp32_add_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_sum;
  logic              rsp_ovf;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       op_count;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit verbose = 1'b1;

  always #5 clk = ~clk;

  fxp32_add_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: what the outputs must be during the current cycle.
  bit          m_valid = 1'b0;
  logic [31:0] m_sum   = '0;
  bit          m_ovf   = 1'b0;
  int          m_id    = 0;
  int          m_ptr   = NREQ - 1;
  logic [15:0] m_cnt   = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NREQ-1:0] exp_rdy;
      int          win;
      logic [31:0] a, b, r;
      check("rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
        check("rsp_sum", rsp_sum, m_sum);
        check("rsp_ovf", rsp_ovf, m_ovf);
        check("rsp_id", rsp_id, m_id);
      end
      check("op_count", op_count, m_cnt);

      exp_rdy = '0;
      win = -1;
      if (!rst && (!m_valid || rsp_ready)) begin
        for (int k = 1; k <= NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (win < 0 && req_valid[idx]) win = idx;
        end
        if (win >= 0) exp_rdy[win] = 1'b1;
      end
      check("req_ready", req_ready, exp_rdy);

      if (verbose && !rst && m_valid && rsp_ready)
        $display("rsp id=%0d sum=%h ovf=%0d count=%0d", rsp_id, rsp_sum, rsp_ovf, op_count);

      if (rst) begin
        m_valid = 1'b0; m_sum = '0; m_ovf = 1'b0; m_id = 0; m_ptr = NREQ - 1; m_cnt = '0;
      end else begin
        if (m_valid && rsp_ready) m_cnt = m_cnt + 16'd1;
        if (win >= 0) begin
          a = req_a[32*win +: 32];
          b = req_b[32*win +: 32];
          if (req_sub[win]) begin
            r = a - b;
            m_ovf = (a[31] != b[31]) && (r[31] != a[31]);
          end else begin
            r = a + b;
            m_ovf = (a[31] == b[31]) && (r[31] != a[31]);
          end
          m_sum = r; m_id = win; m_ptr = win; m_valid = 1'b1;
        end else if (rsp_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input bit sub);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_sub[i] = sub;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    bit          sub;
    logic [31:0] sum;
    bit          ovf;
  } vec_t;

  vec_t vecs[8] = '{
    '{0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b1},
    '{1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1},
    '{2, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0},
    '{3, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0},
    '{0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1},
    '{1, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0},
    '{2, 32'h00000000, 32'h80000000, 1'b1, 32'h80000000, 1'b1},
    '{3, 32'hFFFFFFF6, 32'hFFFFFFFB, 1'b1, 32'hFFFFFFFB, 1'b0}
  };

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    #1;
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_sum", rsp_sum, 32'h0);
    check("reset rsp_ovf", rsp_ovf, 1'b0);
    check("reset rsp_id", rsp_id, 2'd0);
    check("reset op_count", op_count, 16'h0);
    req_valid = 4'hF;
    #1;
    check("reset req_ready", req_ready, 4'b0000);
    req_valid = '0;
    cyc();
    rst = 1'b0;
    rsp_ready = 1'b1;

    // Directed arithmetic vectors, one requester at a time.
    foreach (vecs[v]) begin
      set_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].sub);
      req_valid = 4'b0001 << vecs[v].idx;
      #1;
      check($sformatf("vec%0d req_ready", v), req_ready, 4'b0001 << vecs[v].idx);
      cyc();
      req_valid = '0;
      #1;
      check($sformatf("vec%0d rsp_valid", v), rsp_valid, 1'b1);
      check($sformatf("vec%0d rsp_sum", v), rsp_sum, vecs[v].sum);
      check($sformatf("vec%0d rsp_ovf", v), rsp_ovf, vecs[v].ovf);
      check($sformatf("vec%0d rsp_id", v), rsp_id, vecs[v].idx);
    end
    repeat (2) cyc();

    // All requesters busy after reset: grants 0,1,2,3,0 one per cycle.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h100 * i + 32'h1, 32'h10, 1'b0);
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr grant %0d", k), req_ready, 4'b0001 << (k % 4));
      check($sformatf("rr op_count %0d", k), op_count, (k == 0) ? 0 : k - 1);
      if (k < 4) begin
        cyc();
        #1;
      end
    end

    // Consumer stalls for 5 cycles while FULL with result of requester 3.
    rsp_ready = 1'b0;
    #1;
    check("stall req_ready", req_ready, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      cyc();
      #1;
      check($sformatf("stall%0d rsp_valid", k), rsp_valid, 1'b1);
      check($sformatf("stall%0d rsp_sum", k), rsp_sum, 32'h311);
      check($sformatf("stall%0d rsp_id", k), rsp_id, 2'd3);
      check($sformatf("stall%0d op_count", k), op_count, 16'd3);
      check($sformatf("stall%0d req_ready", k), req_ready, 4'b0000);
    end
    rsp_ready = 1'b1;
    cyc();
    req_valid = '0;
    repeat (2) cyc();

    // Reset one cycle after a grant drops the in-flight result.
    req_valid = 4'b0100;
    cyc();
    req_valid = '0;
    rst = 1'b1;
    #1;
    check("midrst req_ready", req_ready, 4'b0000);
    cyc();
    rst = 1'b0;
    #1;
    check("midrst rsp_valid", rsp_valid, 1'b0);
    req_valid = 4'hF;
    #1;
    check("midrst first grant", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    repeat (2) cyc();

    // op_count wrap: 65535 responses, then one more.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    verbose = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    repeat (65536) cyc();
    #1;
    check("wrap op_count ffff", op_count, 16'hFFFF);
    cyc();
    #1;
    check("wrap op_count 0000", op_count, 16'h0000);
    verbose = 1'b1;
    req_valid = '0;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
